// File: rtl/mux_rr_reg.sv
// N-way arbitrated mux feeding a one-entry registered valid/ready output stage.
// Round-robin (MODE 0) or fixed lowest-index priority (MODE 1) selection.
module mux_rr_reg #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = 0,
    parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel
);

    logic [SELW-1:0]  last;
    logic [SELW-1:0]  grant_idx;
    logic [N-1:0]     grant;
    logic [WIDTH-1:0] grant_data;
    logic             space;
    logic             transfer;

    // Scan starts just past the last winner in round-robin, at channel 0 in fixed priority.
    always_comb begin
        int base;
        int idx;
        grant      = '0;
        grant_idx  = '0;
        grant_data = '0;
        base       = (MODE == 0) ? int'(last) + 1 : 0;
        idx        = 0;
        for (int off = 0; off < N; off++) begin
            idx = (base + off) % N;
            if (grant == '0 && in_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = SELW'(idx);
                grant_data = in_data[idx*WIDTH +: WIDTH];
            end
        end
    end

    assign space    = ~out_valid | out_ready;
    assign in_ready = grant & {N{space & rst_n}};
    assign transfer = |(in_valid & in_ready);

    // A transfer overwrites the register even while draining, so a word moves every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            last      <= SELW'(N - 1);
        end else if (transfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_sel   <= grant_idx;
            if (MODE == 0) begin
                last <= grant_idx;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed bench for mux_rr_reg: a round-robin and a fixed-priority instance share one stimulus.
module tb_mux_rr_reg;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic           out_ready;

    logic [N-1:0]   rr_in_ready,  fp_in_ready;
    logic           rr_out_valid, fp_out_valid;
    logic [W-1:0]   rr_out_data,  fp_out_data;
    logic [1:0]     rr_out_sel,   fp_out_sel;

    int checks = 0;
    int errors = 0;

    mux_rr_reg #(.WIDTH(W), .N(N), .MODE(0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_ready(out_ready),
        .out_data(rr_out_data), .out_sel(rr_out_sel)
    );

    mux_rr_reg #(.WIDTH(W), .N(N), .MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(fp_in_ready), .out_valid(fp_out_valid), .out_ready(out_ready),
        .out_data(fp_out_data), .out_sel(fp_out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_counting_data();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'h100 + i;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = '0;
        @(negedge clk);
        rst_n    = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        load_counting_data();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rr_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b exp 0", rr_out_valid); end
        checks++; if (rr_out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_data got %h exp 0", rr_out_data); end
        checks++; if (rr_out_sel !== 2'd0) begin errors++; $display("[TB] FAIL reset_out_sel got %0d exp 0", rr_out_sel); end
        checks++; if (rr_in_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_in_ready got %b exp 0000", rr_in_ready); end
        checks++; if (fp_in_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_fp_in_ready got %b exp 0000", fp_in_ready); end
        @(negedge clk);
        in_valid = '0;
        rst_n    = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++; if (rr_out_valid !== 1'b0 || rr_out_data !== 32'h0 || rr_out_sel !== 2'd0)
                begin errors++; $display("[TB] FAIL idle_cycle%0d got v=%b d=%h s=%0d exp v=0 d=0 s=0", c, rr_out_valid, rr_out_data, rr_out_sel); end
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        in_valid       = 4'b0100;
        in_data[2*W +: W] = 32'hDEADBEEF;
        out_ready      = 1'b1;
        #1;
        checks++; if (rr_in_ready !== 4'b0100) begin errors++; $display("[TB] FAIL single_in_ready got %b exp 0100", rr_in_ready); end
        @(posedge clk); #1;
        checks++; if (rr_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_out_valid got %b exp 1", rr_out_valid); end
        checks++; if (rr_out_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_out_data got %h exp deadbeef", rr_out_data); end
        checks++; if (rr_out_sel !== 2'd2) begin errors++; $display("[TB] FAIL single_out_sel got %0d exp 2", rr_out_sel); end
        @(negedge clk);
        in_valid = '0;
        @(posedge clk); #1;
        checks++; if (rr_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drain got %b exp 0", rr_out_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        @(negedge clk);
        load_counting_data();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            checks++; if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'(c % 4) || rr_out_data !== 32'h100 + 32'(c % 4))
                begin errors++; $display("[TB] FAIL rr_word%0d got v=%b s=%0d d=%h exp v=1 s=%0d d=%h", c, rr_out_valid, rr_out_sel, rr_out_data, c % 4, 32'h100 + 32'(c % 4)); end
            checks++; if (fp_out_sel !== 2'd0) begin errors++; $display("[TB] FAIL fp_all_valid%0d got %0d exp 0", c, fp_out_sel); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (rr_out_sel !== 2'd0) begin errors++; $display("[TB] FAIL bp_first_sel got %0d exp 0", rr_out_sel); end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        checks++; if (rr_in_ready !== 4'b0000) begin errors++; $display("[TB] FAIL bp_in_ready got %b exp 0000", rr_in_ready); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++; if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'd0 || rr_out_data !== 32'h100)
                begin errors++; $display("[TB] FAIL bp_hold%0d got v=%b s=%0d d=%h exp v=1 s=0 d=100", c, rr_out_valid, rr_out_sel, rr_out_data); end
            checks++; if (rr_in_ready !== 4'b0000 || fp_in_ready !== 4'b0000)
                begin errors++; $display("[TB] FAIL bp_hold_ready%0d got rr=%b fp=%b exp 0000", c, rr_in_ready, fp_in_ready); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++; if (rr_in_ready !== 4'b0010) begin errors++; $display("[TB] FAIL bp_release_ready got %b exp 0010", rr_in_ready); end
        @(posedge clk); #1;
        checks++; if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'd1 || rr_out_data !== 32'h101)
            begin errors++; $display("[TB] FAIL bp_release_word got v=%b s=%0d d=%h exp v=1 s=1 d=101", rr_out_valid, rr_out_sel, rr_out_data); end
    endtask

    task automatic test_fixed_priority();
        @(negedge clk);
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checks++; if (fp_out_valid !== 1'b1 || fp_out_sel !== 2'd1 || fp_out_data !== 32'h101)
                begin errors++; $display("[TB] FAIL fp_word%0d got v=%b s=%0d d=%h exp v=1 s=1 d=101", c, fp_out_valid, fp_out_sel, fp_out_data); end
            checks++; if (rr_out_sel !== ((c % 2 == 0) ? 2'd3 : 2'd1))
                begin errors++; $display("[TB] FAIL rr_alt%0d got %0d exp %0d", c, rr_out_sel, (c % 2 == 0) ? 3 : 1); end
        end
        @(negedge clk);
        in_valid = 4'b1000;
        @(posedge clk); #1;
        checks++; if (fp_out_sel !== 2'd3 || fp_out_data !== 32'h103)
            begin errors++; $display("[TB] FAIL fp_drop1 got s=%0d d=%h exp s=3 d=103", fp_out_sel, fp_out_data); end
        checks++; if (rr_out_sel !== 2'd3) begin errors++; $display("[TB] FAIL rr_drop1 got %0d exp 3", rr_out_sel); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        @(posedge clk); #2;
        checks++; if (rr_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre_valid got %b exp 1", rr_out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (rr_out_valid !== 1'b0 || fp_out_valid !== 1'b0)
            begin errors++; $display("[TB] FAIL arst_valid got rr=%b fp=%b exp 0", rr_out_valid, fp_out_valid); end
        checks++; if (rr_out_data !== 32'h0 || rr_in_ready !== 4'b0000)
            begin errors++; $display("[TB] FAIL arst_state got d=%h r=%b exp d=0 r=0000", rr_out_data, rr_in_ready); end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++; if (rr_in_ready !== 4'b0001 || fp_in_ready !== 4'b0001)
            begin errors++; $display("[TB] FAIL arst_first_ready got rr=%b fp=%b exp 0001", rr_in_ready, fp_in_ready); end
        @(posedge clk); #1;
        checks++; if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'd0 || rr_out_data !== 32'h100)
            begin errors++; $display("[TB] FAIL arst_first_word got v=%b s=%0d d=%h exp v=1 s=0 d=100", rr_out_valid, rr_out_sel, rr_out_data); end
    endtask

    initial begin
        in_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_fixed_priority();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
